// File: rtl/pkt_pkg.sv
// pkt_pkg: constants, helpers and the framer state type for the 0xBE 0xEF
// packet link. The packet error detector imports the same package, so
// framer and detector always agree on the header bytes.
package pkt_pkg;

  localparam logic [7:0] HDR0             = 8'hBE;
  localparam logic [7:0] HDR1             = 8'hEF;
  localparam int         BODY_LEN_DEFAULT = 8;

  // True when b could be mistaken for a header byte on the wire.
  function automatic logic is_hdr_byte(input logic [7:0] b);
    return (b == HDR0) || (b == HDR1);
  endfunction

  // Deliberately wrong checksum for error injection. Flipping bit 0 is the
  // normal choice; if that lands on a header byte, flipping bits 0 and 1
  // cannot also land on one, so the corrupted byte never looks like a header.
  function automatic logic [7:0] corrupt_csum(input logic [7:0] sum);
    logic [7:0] flipped;
    flipped = sum ^ 8'h01;
    if (is_hdr_byte(flipped)) begin
      flipped = sum ^ 8'h03;
    end
    return flipped;
  endfunction

  typedef enum logic [2:0] {
    COLLECT,
    CHECK,
    SEND_H0,
    SEND_H1,
    SEND_BODY,
    SEND_CSUM
  } frm_state_t;

endpackage

// File: rtl/packet_framer.sv
// packet_framer: transmit side of the 0xBE 0xEF packet link.
// Collects BODY_LEN body bytes, rejects bodies that contain a header byte or
// whose checksum would be a header byte, and sends each good body as
// HDR0, HDR1, body bytes, checksum (body sum mod 256).
//
// Ports:
//   clk        clock
//   reset      asynchronous active-high reset
//   in_data    body byte            in_valid / in_ready handshake
//   inj_csum   corrupt this packet's checksum (sampled in CHECK)
//   inj_short  omit the checksum byte (sampled in CHECK)
//   out_data   frame byte           out_valid / out_ready handshake
//   drop       one-cycle pulse when a collected body is discarded
//   pkt_cnt    frames fully sent, wraps modulo 2^CNT_W
module packet_framer
  import pkt_pkg::*;
#(
  parameter int BODY_LEN = BODY_LEN_DEFAULT,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             inj_csum,
  input  logic             inj_short,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             drop,
  output logic [CNT_W-1:0] pkt_cnt
);

  localparam int              IDX_W    = (BODY_LEN > 1) ? $clog2(BODY_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BODY_LEN - 1);

  frm_state_t       state;
  frm_state_t       state_next;

  // idx is the write pointer while collecting and the read pointer while
  // sending the body; it is back at zero whenever a phase starts.
  logic [IDX_W-1:0] idx;
  logic [7:0]       sum;
  logic             illegal;
  logic [7:0]       csum;
  logic             short_frame;
  logic [7:0]       body_mem [BODY_LEN];

  logic             last_idx;
  logic             bad_body;
  logic             frame_done;

  assign last_idx = (idx == LAST_IDX);
  assign bad_body = illegal || is_hdr_byte(sum);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // Next state and handshake outputs. Outputs are decoded from registered
  // state, so reset forces them to their idle values immediately.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    drop       = 1'b0;
    frame_done = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && last_idx) begin
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (bad_body) begin
          drop       = 1'b1;
          state_next = COLLECT;
        end else begin
          state_next = SEND_H0;
        end
      end
      SEND_H0: begin
        out_valid = 1'b1;
        out_data  = HDR0;
        if (out_ready) begin
          state_next = SEND_H1;
        end
      end
      SEND_H1: begin
        out_valid = 1'b1;
        out_data  = HDR1;
        if (out_ready) begin
          state_next = SEND_BODY;
        end
      end
      SEND_BODY: begin
        out_valid = 1'b1;
        out_data  = body_mem[idx];
        if (out_ready && last_idx) begin
          if (short_frame) begin
            state_next = COLLECT;
            frame_done = 1'b1;
          end else begin
            state_next = SEND_CSUM;
          end
        end
      end
      SEND_CSUM: begin
        out_valid = 1'b1;
        out_data  = csum;
        if (out_ready) begin
          state_next = COLLECT;
          frame_done = 1'b1;
        end
      end
      default: begin
        state_next = COLLECT;
      end
    endcase
  end

  // Index, running sum, validity flag, latched checksum and frame counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      sum         <= 8'h00;
      illegal     <= 1'b0;
      csum        <= 8'h00;
      short_frame <= 1'b0;
      pkt_cnt     <= '0;
    end else begin
      if (frame_done) begin
        pkt_cnt <= pkt_cnt + 1'b1;
      end
      case (state)
        COLLECT: begin
          if (in_valid) begin
            sum     <= sum + in_data;
            illegal <= illegal | is_hdr_byte(in_data);
            idx     <= last_idx ? '0 : idx + 1'b1;
          end
        end
        CHECK: begin
          // Accumulators are cleared either way so the next body starts
          // fresh; checksum and injection flags matter only for a good body.
          sum     <= 8'h00;
          illegal <= 1'b0;
          idx     <= '0;
          if (!bad_body) begin
            csum        <= inj_csum ? corrupt_csum(sum) : sum;
            short_frame <= inj_short;
          end
        end
        SEND_BODY: begin
          if (out_ready) begin
            idx <= last_idx ? '0 : idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Body buffer: written only while collecting, read while sending. No reset
  // needed because every entry is rewritten before it is sent.
  always_ff @(posedge clk) begin
    if (state == COLLECT && in_valid) begin
      body_mem[idx] <= in_data;
    end
  end

endmodule
